// File: rtl/guess_compare.sv
// Number-guessing round controller fed by an 11-bit LFSR.
// The LFSR value is captured as the secret target when a round starts.
// Each valid guess is scored as too high, too low or a match, and is counted.
// A round ends on a match (WIN) or when the attempt budget runs out (LOSE).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, no round yet; LFSR free-runs
//   PLAY  | round in progress; LFSR frozen, guesses are scored
//   WIN   | last guess matched; target revealed, LFSR free-runs
//   LOSE  | attempt budget spent without a match; target revealed
module guess_compare #(
  parameter int WIDTH     = 11,
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] num,
  input  logic             start,
  input  logic [WIDTH-1:0] guess,
  input  logic             guess_valid,
  output logic [1:0]       lfsr_en,
  output logic             busy,
  output logic             too_high,
  output logic             too_low,
  output logic             match,
  output logic             game_over,
  output logic [TRY_W-1:0] tries,
  output logic [WIDTH-1:0] target
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] secret_q, secret_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             too_high_q, too_high_d;
  logic             too_low_q, too_low_d;
  logic             match_q, match_d;
  logic             game_over_q, game_over_d;
  logic             busy_q, busy_d;
  logic [1:0]       lfsr_en_q, lfsr_en_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [TRY_W-1:0] tries_inc;

  // Next-state, scoring and registered-output computation
  always_comb begin
    state_d     = state_q;
    secret_d    = secret_q;
    tries_d     = tries_q;
    too_high_d  = too_high_q;
    too_low_d   = too_low_q;
    match_d     = match_q;
    game_over_d = game_over_q;
    tries_inc   = tries_q + 1'b1;

    if (start) begin
      // start wins over a coincident guess in every state, including PLAY
      state_d     = S_PLAY;
      secret_d    = num;
      tries_d     = '0;
      too_high_d  = 1'b0;
      too_low_d   = 1'b0;
      match_d     = 1'b0;
      game_over_d = 1'b0;
    end else if (guess_valid && (state_q == S_PLAY)) begin
      tries_d    = tries_inc;
      too_high_d = (guess > secret_q);
      too_low_d  = (guess < secret_q);
      match_d    = (guess == secret_q);
      if (guess == secret_q) begin
        state_d = S_WIN;
      end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
        state_d     = S_LOSE;
        game_over_d = 1'b1;
      end
    end

    // Status outputs are derived from the next state so they line up with it
    busy_d    = (state_d == S_PLAY);
    lfsr_en_d = {1'b0, (state_d != S_PLAY)};
    target_d  = ((state_d == S_WIN) || (state_d == S_LOSE)) ? secret_d : '0;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      secret_q    <= '0;
      tries_q     <= '0;
      too_high_q  <= 1'b0;
      too_low_q   <= 1'b0;
      match_q     <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      lfsr_en_q   <= 2'b01;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      secret_q    <= secret_d;
      tries_q     <= tries_d;
      too_high_q  <= too_high_d;
      too_low_q   <= too_low_d;
      match_q     <= match_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
      lfsr_en_q   <= lfsr_en_d;
      target_q    <= target_d;
    end
  end

  assign lfsr_en   = lfsr_en_q;
  assign busy      = busy_q;
  assign too_high  = too_high_q;
  assign too_low   = too_low_q;
  assign match     = match_q;
  assign game_over = game_over_q;
  assign tries     = tries_q;
  assign target    = target_q;

endmodule

// File: tb/tb_guess_compare.sv
// Self-checking bench for guess_compare: directed scenarios plus a randomized
// run, all compared against a round-level model of the game.
module tb_guess_compare;

  localparam int WIDTH     = 11;
  localparam int MAX_TRIES = 8;
  localparam int TRY_W     = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] num = '0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] guess = '0;
  logic             guess_valid = 1'b0;
  logic [1:0]       lfsr_en;
  logic             busy, too_high, too_low, match, game_over;
  logic [TRY_W-1:0] tries;
  logic [WIDTH-1:0] target;

  int n_checks = 0;
  int n_pass   = 0;

  guess_compare #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
    .clk(clk), .reset_n(reset_n), .num(num), .start(start), .guess(guess),
    .guess_valid(guess_valid), .lfsr_en(lfsr_en), .busy(busy),
    .too_high(too_high), .too_low(too_low), .match(match),
    .game_over(game_over), .tries(tries), .target(target)
  );

  always #5 clk = ~clk;

  // Game model: round phase, the secret, attempts used and last verdict.
  typedef enum int {PH_IDLE, PH_PLAY, PH_WON, PH_LOST} phase_t;
  phase_t m_phase = PH_IDLE;
  int     m_secret = 0;
  int     m_tries = 0;
  bit     m_hi = 0, m_lo = 0, m_eq = 0, m_over = 0;

  function automatic void model_step(bit rn, bit st, bit gv, int g, int n);
    if (!rn) begin
      m_phase = PH_IDLE; m_secret = 0; m_tries = 0;
      m_hi = 0; m_lo = 0; m_eq = 0; m_over = 0;
    end else if (st) begin
      m_phase = PH_PLAY; m_secret = n; m_tries = 0;
      m_hi = 0; m_lo = 0; m_eq = 0; m_over = 0;
    end else if (gv && m_phase == PH_PLAY) begin
      m_tries = m_tries + 1;
      m_hi = (g > m_secret);
      m_lo = (g < m_secret);
      m_eq = (g == m_secret);
      if (m_eq) m_phase = PH_WON;
      else if (m_tries == MAX_TRIES) begin
        m_phase = PH_LOST;
        m_over  = 1;
      end
    end
  endfunction

  // Expected output vector {lfsr_en, busy, hi, lo, eq, over, tries, target}
  function automatic logic [21:0] model_vec();
    logic [1:0]       le;
    logic [WIDTH-1:0] tg;
    logic [TRY_W-1:0] tr;
    le = (m_phase == PH_PLAY) ? 2'b00 : 2'b01;
    tg = (m_phase == PH_WON || m_phase == PH_LOST) ? WIDTH'(m_secret) : '0;
    tr = TRY_W'(m_tries);
    return {le, (m_phase == PH_PLAY), m_hi, m_lo, m_eq, m_over, tr, tg};
  endfunction

  logic [21:0] obs;
  assign obs = {lfsr_en, busy, too_high, too_low, match, game_over, tries, target};

  // One clock: drive at negedge, advance model at posedge, settle 1 time unit
  task automatic tick(input bit rn, input bit st, input bit gv,
                      input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] n);
    @(negedge clk);
    reset_n = rn; start = st; guess_valid = gv; guess = g; num = n;
    @(posedge clk);
    model_step(rn, st, gv, int'(g), int'(n));
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, '0, 11'h123);
    tick(0, 1, 1, 11'h55, 11'h123);
    n_checks++;
    if (obs !== {2'b01, 1'b0, 4'b0000, 4'd0, 11'h000})
      $display("FAIL reset_state obs=%h exp=%h", obs, {2'b01, 1'b0, 4'b0000, 4'd0, 11'h000});
    else n_pass++;
    tick(1, 0, 1, 11'h10, 11'h321);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL reset_idle_guess obs=%h exp=%h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_win();
    logic [WIDTH-1:0] gs [3] = '{11'h100, 11'h3FF, 11'h2A5};
    tick(1, 1, 0, '0, 11'h2A5);
    n_checks++;
    if (obs !== model_vec() || busy !== 1'b1 || lfsr_en !== 2'b00)
      $display("FAIL win_start obs=%h exp=%h", obs, model_vec());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, gs[i], 11'h0F0);
      n_checks++;
      if (obs !== model_vec()) $display("FAIL win_guess%0d obs=%h exp=%h", i, obs, model_vec());
      else n_pass++;
    end
    n_checks++;
    if ({match, too_high, too_low, tries, busy, target, lfsr_en} !==
        {1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 11'h2A5, 2'b01})
      $display("FAIL win_final match=%b tries=%0d busy=%b target=%h lfsr_en=%b exp match=1 tries=3 busy=0 target=2a5 lfsr_en=01",
               match, tries, busy, target, lfsr_en);
    else n_pass++;
  endtask

  task automatic test_lose();
    tick(1, 1, 0, '0, 11'h010);
    for (int i = 0; i < MAX_TRIES; i++) begin
      tick(1, 0, 1, 11'h000, 11'h222);
      n_checks++;
      if (obs !== model_vec() || too_low !== 1'b1)
        $display("FAIL lose_guess%0d obs=%h exp=%h", i, obs, model_vec());
      else n_pass++;
    end
    n_checks++;
    if ({game_over, tries, busy, target} !== {1'b1, 4'd8, 1'b0, 11'h010})
      $display("FAIL lose_final over=%b tries=%0d busy=%b target=%h exp over=1 tries=8 busy=0 target=010",
               game_over, tries, busy, target);
    else n_pass++;
    tick(1, 0, 1, 11'h010, 11'h222);
    n_checks++;
    if (obs !== model_vec() || tries !== 4'd8 || match !== 1'b0)
      $display("FAIL lose_ninth obs=%h exp=%h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_collision();
    tick(1, 1, 0, '0, 11'h200);
    tick(1, 0, 1, 11'h001, '0);
    tick(1, 0, 1, 11'h7F0, '0);
    n_checks++;
    if (tries !== 4'd2) $display("FAIL coll_pre tries=%0d exp=2", tries);
    else n_pass++;
    tick(1, 1, 1, 11'h200, 11'h7FF);
    n_checks++;
    if (obs !== model_vec() || {tries, too_high, too_low, match, game_over} !== 8'h00)
      $display("FAIL coll_restart obs=%h exp=%h", obs, model_vec());
    else n_pass++;
    tick(1, 0, 1, 11'h7FF, '0);
    n_checks++;
    if ({match, target, tries} !== {1'b1, 11'h7FF, 4'd1})
      $display("FAIL coll_target match=%b target=%h tries=%0d exp match=1 target=7ff tries=1",
               match, target, tries);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    tick(1, 1, 0, '0, 11'h400);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 11'h003, '0);
    n_checks++;
    if (tries !== 4'd5) $display("FAIL midrst_pre tries=%0d exp=5", tries);
    else n_pass++;
    tick(0, 0, 0, '0, '0);
    n_checks++;
    if (obs !== {2'b01, 1'b0, 4'b0000, 4'd0, 11'h000})
      $display("FAIL midrst_state obs=%h exp=%h", obs, {2'b01, 1'b0, 4'b0000, 4'd0, 11'h000});
    else n_pass++;
    tick(1, 0, 1, 11'h400, '0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL midrst_after obs=%h exp=%h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_extremes();
    tick(1, 1, 0, '0, 11'h000);
    tick(1, 0, 1, 11'h7FF, '0);
    n_checks++;
    if ({too_high, too_low, match} !== 3'b100)
      $display("FAIL ext_high hi/lo/eq=%b exp=100", {too_high, too_low, match});
    else n_pass++;
    tick(1, 0, 1, 11'h000, '0);
    n_checks++;
    if ({match, target, game_over} !== {1'b1, 11'h000, 1'b0})
      $display("FAIL ext_zero_target match=%b target=%h over=%b exp 1 000 0", match, target, game_over);
    else n_pass++;
    tick(1, 1, 0, '0, 11'h7FF);
    tick(1, 0, 1, 11'h000, '0);
    n_checks++;
    if ({too_high, too_low, match} !== 3'b010)
      $display("FAIL ext_low hi/lo/eq=%b exp=010", {too_high, too_low, match});
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      bit rn, st, gv;
      logic [WIDTH-1:0] g, n;
      rn = ($urandom_range(0, 127) != 0);
      st = ($urandom_range(0, 19) == 0);
      gv = ($urandom_range(0, 2) == 0);
      n  = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       g = WIDTH'(m_secret);
        1:       g = WIDTH'(m_secret + 1);
        2:       g = WIDTH'(m_secret - 1);
        default: g = WIDTH'($urandom);
      endcase
      tick(rn, st, gv, g, n);
      n_checks++;
      if (obs !== model_vec()) begin
        if (errs < 10) $display("FAIL random_cycle%0d obs=%h exp=%h", i, obs, model_vec());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_collision();
    test_mid_reset();
    test_extremes();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
